// File: rtl/watchdog_ctrl.sv
// watchdog_ctrl: bus-kicked system watchdog with a prescaled tick counter.
// Holds nRESET low for HOLD_TICKS ticks after RST or a timeout. Releases it,
// then expects a kick at least every TIMEOUT_TICKS ticks while WD_EN is high.
// Optional feature: define WATCHDOG_WINDOW_EN to treat kicks that arrive while
// CNT < WINDOW_TICKS as early-kick violations (WD_CAUSE = 10).
// Bus handshake: BUS_WR is a single-cycle write strobe qualified by BUS_ADDR
// and BUS_DATA in the same cycle; there is no ready/back-pressure, so every
// strobe is consumed in the cycle it is presented.
module watchdog_ctrl #(
    parameter int                ADDR_W        = 24,
    parameter logic [ADDR_W-1:0] KICK_ADDR     = ADDR_W'(24'h300001),
    parameter logic [ADDR_W-1:0] ADDR_MASK     = ADDR_W'(24'hF1FFFF),
    parameter bit                KEY_CHK       = 1'b0,
    parameter logic [7:0]        KICK_KEY      = 8'h00,
    parameter int                PRESCALE      = 4096,
    parameter int                TIMEOUT_TICKS = 8,
    parameter int                HOLD_TICKS    = 8,
    parameter int                WINDOW_TICKS  = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              BUS_WR,
    input  logic [ADDR_W-1:0] BUS_ADDR,
    input  logic [7:0]        BUS_DATA,
    input  logic              WD_EN,
    output logic              nRESET,
    output logic [1:0]        WD_CAUSE,
    output logic              WD_TICK
);

    localparam int MAX_TICKS = (TIMEOUT_TICKS > HOLD_TICKS) ? TIMEOUT_TICKS : HOLD_TICKS;
    localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam int CNT_RANGE = 2 ** CNT_W;
    localparam int PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_TICKS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST     = PRE_W'(PRESCALE - 1);

`ifdef WATCHDOG_WINDOW_EN
    localparam bit WINDOW_ON = 1'b1;
`else
    localparam bit WINDOW_ON = 1'b0;
`endif

    // One bit per CNT value: set where a kick would be too early.
    function automatic logic [CNT_RANGE-1:0] win_mask_f();
        logic [CNT_RANGE-1:0] m;
        m = '0;
        for (int i = 0; i < CNT_RANGE; i++) begin
            m[i] = (i < WINDOW_TICKS);
        end
        return m;
    endfunction

    localparam logic [CNT_RANGE-1:0] WIN_MASK = win_mask_f();

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [PRE_W-1:0] pre, pre_n;
    logic [1:0]       cause, cause_n;
    logic             nreset_q;

    logic             addr_hit;
    logic             key_ok;
    logic             kick;
    logic             tick;
    logic             early_kick;

    assign addr_hit   = ((BUS_ADDR ^ KICK_ADDR) & ADDR_MASK) == '0;
    assign key_ok     = !KEY_CHK || (BUS_DATA == KICK_KEY);
    assign kick       = BUS_WR && addr_hit && key_ok;
    assign tick       = (pre == PRE_LAST);
    assign early_kick = WINDOW_ON && kick && WIN_MASK[cnt];

    // Next-state, tick counter, prescaler and cause decisions.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cause_n = cause;
        pre_n   = tick ? '0 : pre + PRE_W'(1);
        case (state)
            ST_HOLD: begin
                // Kicks and WD_EN are deliberately ignored while holding.
                if (tick) begin
                    if (cnt == HOLD_LAST) begin
                        state_n = ST_RUN;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (early_kick) begin
                    state_n = ST_HOLD;
                    cnt_n   = '0;
                    pre_n   = '0;
                    cause_n = 2'b10;
                end else if (kick) begin
                    // A kick wins over a timeout tick in the same cycle.
                    cnt_n = '0;
                    pre_n = '0;
                end else if (WD_EN && tick) begin
                    if (cnt == TIMEOUT_LAST) begin
                        state_n = ST_HOLD;
                        cnt_n   = '0;
                        cause_n = 2'b01;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_n = ST_HOLD;
        endcase
    end

    // State register; nRESET follows the state one cycle behind the decision.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_HOLD;
            cnt      <= '0;
            pre      <= '0;
            cause    <= 2'b00;
            nreset_q <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            pre      <= pre_n;
            cause    <= cause_n;
            nreset_q <= (state == ST_RUN);
        end
    end

    assign nRESET   = nreset_q;
    assign WD_CAUSE = cause;
    assign WD_TICK  = tick && !RST;

endmodule

// File: tb/tb_watchdog_ctrl.sv
// tb_watchdog_ctrl: directed scenarios with hand-computed edge counts, then
// randomized bus/enable/reset traffic, all checked every cycle against a
// tick-counting reference model. Build with +define+WATCHDOG_WINDOW_EN to
// exercise the early-kick window.
module tb_watchdog_ctrl;

  localparam int P  = 4;
  localparam int TO = 8;
  localparam int HT = 8;
  localparam int WT = 2;
  localparam logic [23:0] K_ADDR = 24'h300001;
  localparam logic [23:0] K_MASK = 24'hF1FFFF;
  localparam bit          K_CHK  = 1'b0;
  localparam logic [7:0]  K_KEY  = 8'h00;
`ifdef WATCHDOG_WINDOW_EN
  localparam bit WIN_ON = 1'b1;
`else
  localparam bit WIN_ON = 1'b0;
`endif

  // ---------------- clock / reset / stimulus signals ----------------
  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        wr   = 1'b0;
  logic [23:0] addr = 24'h0;
  logic [7:0]  data = 8'h0;
  logic        en   = 1'b1;
  logic        nreset;
  logic [1:0]  wd_cause;
  logic        wd_tick;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  watchdog_ctrl #(
    .ADDR_W       (24),
    .KICK_ADDR    (K_ADDR),
    .ADDR_MASK    (K_MASK),
    .KEY_CHK      (K_CHK),
    .KICK_KEY     (K_KEY),
    .PRESCALE     (P),
    .TIMEOUT_TICKS(TO),
    .HOLD_TICKS   (HT),
    .WINDOW_TICKS (WT)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .BUS_WR  (wr),
    .BUS_ADDR(addr),
    .BUS_DATA(data),
    .WD_EN   (en),
    .nRESET  (nreset),
    .WD_CAUSE(wd_cause),
    .WD_TICK (wd_tick)
  );

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the current cycle number, the cycle in which the prescaler last
  // restarted from zero, and how many qualifying ticks have elapsed in the
  // current phase (holding or released).
  int cyc     = 0;
  bit m_valid = 1'b0;
  bit m_run   = 1'b0;
  int m_ticks = 0;
  int m_zero  = 0;
  int m_cause = 0;
  int m_nres  = 0;

  always @(posedge clk) begin : model
    bit tk;
    bit kk;
    tk = ((cyc - m_zero) % P) == (P - 1);
    kk = wr && ((addr & K_MASK) == (K_ADDR & K_MASK)) && (!K_CHK || data == K_KEY);
    if (rst) begin
      m_valid = 1'b1;
      m_nres  = 0;
      m_run   = 1'b0;
      m_ticks = 0;
      m_zero  = cyc + 1;
      m_cause = 0;
    end else if (m_valid) begin
      m_nres = m_run ? 1 : 0;
      if (!m_run) begin
        if (tk) begin
          m_ticks++;
          if (m_ticks == HT) begin
            m_run   = 1'b1;
            m_ticks = 0;
          end
        end
      end else if (kk && WIN_ON && m_ticks < WT) begin
        m_run   = 1'b0;
        m_ticks = 0;
        m_zero  = cyc + 1;
        m_cause = 2;
      end else if (kk) begin
        m_ticks = 0;
        m_zero  = cyc + 1;
      end else if (en && tk) begin
        m_ticks++;
        if (m_ticks == TO) begin
          m_run   = 1'b0;
          m_ticks = 0;
          m_cause = 1;
        end
      end
    end
    cyc++;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      check("nreset", int'(nreset), m_nres);
      check("cause", int'(wd_cause), m_cause);
      check("tick", int'(wd_tick), (!rst && (((cyc - m_zero) % P) == (P - 1))) ? 1 : 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [23:0] a);
    addr = a;
    data = 8'($urandom);
    wr   = 1'b1;
    @(posedge clk);
    #1;
    wr = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Counts edges until nRESET reaches lvl (bounded), optionally writing
  // address a every 'period' cycles meanwhile.
  task automatic run_count(input logic lvl, input int limit, input int period,
                           input logic [23:0] a, output int n);
    n    = 0;
    addr = a;
    do begin
      if (period > 0) wr = ((n % period) == (period - 1));
      else            wr = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end while (nreset !== lvl && n < limit);
    wr = 1'b0;
  endtask

  // Periodic writes for 'cycles' cycles; returns how many samples saw nRESET low.
  task automatic periodic(input int cycles, input int period, input logic [23:0] a,
                          output int lows);
    lows = 0;
    addr = a;
    for (int c = 0; c < cycles; c++) begin
      wr = ((c % period) == 0);
      @(posedge clk);
      #1;
      if (nreset !== 1'b1) lows++;
    end
    wr = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin : main
    int n;
    int lows;
    int rate;

    // Power-on stretch: 3 cycles of RST, release on the 33rd edge after.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    run_count(1'b1, 200, 0, K_ADDR, n);
    check("poweron_rise_edge", n, 33);
    check("poweron_cause", int'(wd_cause), 0);

    // Timeout with no kicks: 32 cycles high, 32 cycles low.
    run_count(1'b0, 200, 0, K_ADDR, n);
    check("timeout_high_len", n, 32);
    check("timeout_cause", int'(wd_cause), 1);
    run_count(1'b1, 200, 0, K_ADDR, n);
    check("timeout_low_len", n, 32);
    check("timeout_cause_after", int'(wd_cause), 1);

    // Kick every 20 cycles keeps nRESET high for 1000 cycles.
    periodic(1000, 20, K_ADDR, lows);
    check("periodic_no_reset", lows, 0);

    // Writes to a non-matching address are not kicks.
    bus_write(K_ADDR);
    run_count(1'b0, 200, 10, 24'h300003, n);
    check("bad_addr_timeout", n, 33);
    check("bad_addr_cause", int'(wd_cause), 1);

    // Kicks during hold do not shorten or stretch it.
    run_count(1'b1, 200, 3, K_ADDR, n);
    check("hold_kicks_len", n, 32);

    // Masked address bit 17: still a kick.
    periodic(300, 20, 24'h320001, lows);
    check("masked_kick", lows, 0);

    // Kick in the same cycle as the 8th tick wins over the timeout.
    bus_write(K_ADDR);
    idle(31);
    bus_write(K_ADDR);
    run_count(1'b0, 200, 0, K_ADDR, n);
    check("kick_tick_race", n, 33);

    // RST in the middle of hold restarts a full hold with cause 00.
    idle(10);
    pulse_rst();
    run_count(1'b1, 200, 0, K_ADDR, n);
    check("rst_mid_hold_len", n, 33);
    check("rst_mid_hold_cause", int'(wd_cause), 0);

    // RST in the middle of run after a timeout.
    run_count(1'b0, 200, 0, K_ADDR, n);
    check("timeout2_high_len", n, 32);
    run_count(1'b1, 200, 0, K_ADDR, n);
    check("timeout2_low_len", n, 32);
    idle(10);
    pulse_rst();
    run_count(1'b1, 200, 0, K_ADDR, n);
    check("rst_mid_run_len", n, 33);
    check("rst_mid_run_cause", int'(wd_cause), 0);

    // WD_EN low after 5 ticks freezes the count; 3 more ticks after re-enable.
    bus_write(K_ADDR);
    idle(20);
    en = 1'b0;
    idle(100);
    en = 1'b1;
    run_count(1'b0, 200, 0, K_ADDR, n);
    check("wd_en_resume", n, 13);
    run_count(1'b1, 200, 0, K_ADDR, n);
    check("wd_en_hold_len", n, 32);

    // Early kick 2 cycles after the previous kick.
    bus_write(K_ADDR);
    idle(1);
    bus_write(K_ADDR);
    run_count(1'b0, 200, 0, K_ADDR, n);
    check("early_kick_edge", n, WIN_ON ? 1 : 33);
    check("early_kick_cause", int'(wd_cause), WIN_ON ? 2 : 1);
    run_count(1'b1, 200, 0, K_ADDR, n);
    check("early_kick_hold_len", n, 32);

    // Kick 12 cycles after the previous one is a normal kick.
    bus_write(K_ADDR);
    idle(11);
    bus_write(K_ADDR);
    run_count(1'b0, 200, 0, K_ADDR, n);
    check("late_kick_normal", n, 33);
    check("late_kick_cause", int'(wd_cause), 1);
    run_count(1'b1, 200, 0, K_ADDR, n);

    // Randomized traffic, checked every cycle by the model.
    for (int seg = 0; seg < 6; seg++) begin
      rate = $urandom_range(2, 40);
      for (int c = 0; c < 500; c++) begin
        rst = ($urandom_range(0, 399) == 0);
        wr  = ($urandom_range(0, rate) == 0);
        case ($urandom_range(0, 4))
          0:       addr = K_ADDR;
          1:       addr = 24'h300003;
          2:       addr = 24'h320001;
          3:       addr = 24'h310001;
          default: addr = 24'($urandom);
        endcase
        data = 8'($urandom);
        if ($urandom_range(0, 59) == 0) en = ~en;
        @(posedge clk);
        #1;
      end
    end
    rst = 1'b0;
    wr  = 1'b0;
    en  = 1'b1;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound.
  initial begin : guard
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad + 1);
    $fatal(1, "time limit");
  end

endmodule
